// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction
// fetch (IF) and data memory (DM) requesters. DM has priority; a starvation
// counter forces an IF win after STARVE_LIMIT consecutive denied cycles.
// Commands are registered, reads return two cycles after grant, and a
// 2-deep tag pipe routes each return to its requester.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  flush,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DATA_WIDTH-1:0] mem_w_data,
  input  logic [DATA_WIDTH-1:0] mem_r_data,
  output logic [15:0]           if_wait_cnt
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0]            starve_cnt;
  logic                  starved;
  logic                  if_wait;
  logic                  push_vld;
  logic                  push_if;
  logic                  tag_vld_p1;
  logic                  tag_if_p1;
  logic                  tag_vld_p2;
  logic                  tag_if_p2;
  logic [DATA_WIDTH-1:0] if_rdata_q;
  logic [DATA_WIDTH-1:0] dm_rdata_q;

  function automatic logic [7:0] sat_starve(input logic [7:0] v);
    return (v >= LIMIT) ? LIMIT : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_wait(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign starved = (starve_cnt == LIMIT);

  // Grant selection: DM first unless IF has been starved; flush blocks a lone IF.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (!rst) begin
      if (dm_req && if_req) begin
        if (starved) if_gnt = 1'b1;
        else         dm_gnt = 1'b1;
      end else if (dm_req) begin
        dm_gnt = 1'b1;
      end else if (if_req && !flush) begin
        if_gnt = 1'b1;
      end
    end
  end

  assign if_wait  = if_req & ~if_gnt;
  assign push_if  = if_gnt;
  assign push_vld = if_gnt | (dm_gnt & ~dm_we);

  // Stage p0 -> p1: register the winning command toward the memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_w_data <= '0;
    end else if (dm_gnt) begin
      mem_addr   <= dm_addr;
      mem_rd     <= ~dm_we;
      mem_wr     <= dm_we;
      mem_w_data <= dm_wdata;
    end else if (if_gnt) begin
      mem_addr   <= if_addr;
      mem_rd     <= 1'b1;
      mem_wr     <= 1'b0;
    end else begin
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
    end
  end

  // Return tag pipe p1 -> p2; flush kills every in-flight IF tag, including one entering now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld_p1 <= 1'b0;
      tag_if_p1  <= 1'b0;
      tag_vld_p2 <= 1'b0;
      tag_if_p2  <= 1'b0;
    end else begin
      tag_vld_p1 <= push_vld & ~(push_if & flush);
      tag_if_p1  <= push_if;
      tag_vld_p2 <= tag_vld_p1 & ~(tag_if_p1 & flush);
      tag_if_p2  <= tag_if_p1;
    end
  end

  assign if_rvalid = tag_vld_p2 &  tag_if_p2 & ~flush;
  assign dm_rvalid = tag_vld_p2 & ~tag_if_p2;
  assign if_rdata  = if_rvalid ? mem_r_data : if_rdata_q;
  assign dm_rdata  = dm_rvalid ? mem_r_data : dm_rdata_q;

  // Hold the last delivered read data for each requester between returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (if_rvalid) if_rdata_q <= mem_r_data;
      if (dm_rvalid) dm_rdata_q <= mem_r_data;
    end
  end

  // Starvation and wait counters both advance on every cycle IF is left waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt  <= 8'd0;
      if_wait_cnt <= 16'd0;
    end else begin
      starve_cnt <= if_wait ? sat_starve(starve_cnt) : 8'd0;
      if (if_wait) if_wait_cnt <= sat_wait(if_wait_cnt);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int LIMIT = 4;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          flush;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_w_data;
  logic [DW-1:0] mem_r_data;
  logic [15:0]   if_wait_cnt;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .flush(flush),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_w_data(mem_w_data), .mem_r_data(mem_r_data), .if_wait_cnt(if_wait_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared single-port memory: registered read, write at the edge.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_w_data;
    if (mem_rd) mem_r_data <= mem[mem_addr];
  end

  // Reference model state
  typedef struct { int due; bit is_if; logic [DW-1:0] data; } pend_t;
  pend_t         pq[$];
  logic [DW-1:0] ref_mem [256];
  int            cyc;
  int            m_starve;
  int            m_wait;
  logic [AW-1:0] e_addr;
  logic          e_rd, e_wr;
  logic [DW-1:0] e_wdata;
  logic [DW-1:0] h_if, h_dm, rdat;
  logic          e_if_gnt, e_dm_gnt, e_if_rv, e_dm_rv;
  logic [DW-1:0] e_if_rdo, e_dm_rdo;

  int n_vec;
  int n_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    pq.delete();
    m_starve = 0; m_wait = 0;
    e_addr = '0; e_rd = 1'b0; e_wr = 1'b0; e_wdata = '0;
    h_if = '0; h_dm = '0;
  endtask

  // Expected combinational view for the current cycle.
  task automatic model_comb();
    e_if_gnt = if_req && (dm_req ? (m_starve == LIMIT) : !flush);
    e_dm_gnt = dm_req && !e_if_gnt;
    e_if_rv = 1'b0; e_dm_rv = 1'b0; rdat = '0;
    foreach (pq[i]) begin
      if (pq[i].due == cyc) begin
        if (pq[i].is_if) e_if_rv = !flush;
        else             e_dm_rv = 1'b1;
        rdat = pq[i].data;
      end
    end
    e_if_rdo = e_if_rv ? rdat : h_if;
    e_dm_rdo = e_dm_rv ? rdat : h_dm;
  endtask

  // Advance the model across one clock edge (inputs still held).
  task automatic model_edge();
    pend_t nq[$];
    pend_t p;
    if (e_if_rv) h_if = rdat;
    if (e_dm_rv) h_dm = rdat;
    foreach (pq[i])
      if (pq[i].due > cyc && !(flush && pq[i].is_if)) nq.push_back(pq[i]);
    pq = nq;
    if (e_dm_gnt) begin
      e_addr = dm_addr; e_rd = !dm_we; e_wr = dm_we; e_wdata = dm_wdata;
      if (dm_we) ref_mem[dm_addr] = dm_wdata;
      else begin
        p.due = cyc + 2; p.is_if = 1'b0; p.data = ref_mem[dm_addr];
        pq.push_back(p);
      end
    end else if (e_if_gnt) begin
      e_addr = if_addr; e_rd = 1'b1; e_wr = 1'b0;
      if (!flush) begin
        p.due = cyc + 2; p.is_if = 1'b1; p.data = ref_mem[if_addr];
        pq.push_back(p);
      end
    end else begin
      e_rd = 1'b0; e_wr = 1'b0;
    end
    if (if_req && !e_if_gnt) begin
      m_starve = (m_starve >= LIMIT) ? LIMIT : m_starve + 1;
      if (m_wait < 65535) m_wait++;
    end else begin
      m_starve = 0;
    end
    cyc++;
  endtask

  task automatic check_all();
    chk("if_gnt",      {31'd0, if_gnt},    {31'd0, e_if_gnt});
    chk("dm_gnt",      {31'd0, dm_gnt},    {31'd0, e_dm_gnt});
    chk("if_rvalid",   {31'd0, if_rvalid}, {31'd0, e_if_rv});
    chk("dm_rvalid",   {31'd0, dm_rvalid}, {31'd0, e_dm_rv});
    chk("if_rdata",    {16'd0, if_rdata},  {16'd0, e_if_rdo});
    chk("dm_rdata",    {16'd0, dm_rdata},  {16'd0, e_dm_rdo});
    chk("mem_addr",    {24'd0, mem_addr},  {24'd0, e_addr});
    chk("mem_rd",      {31'd0, mem_rd},    {31'd0, e_rd});
    chk("mem_wr",      {31'd0, mem_wr},    {31'd0, e_wr});
    chk("mem_w_data",  {16'd0, mem_w_data},{16'd0, e_wdata});
    chk("if_wait_cnt", {16'd0, if_wait_cnt}, 32'(m_wait));
  endtask

  // One clock cycle: drive inputs, check, cross the edge, update the model.
  task automatic cycle(input logic ir, input logic [AW-1:0] ia, input logic fl,
                       input logic dr, input logic dw, input logic [AW-1:0] da,
                       input logic [DW-1:0] dwd);
    if_req = ir; if_addr = ia; flush = fl;
    dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dwd;
    #1;
    model_comb();
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop at once.
  task automatic do_reset();
    if_req = 1'b0; dm_req = 1'b0; flush = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mem_rd",    {31'd0, mem_rd},    32'd0);
    chk("rst_mem_wr",    {31'd0, mem_wr},    32'd0);
    chk("rst_mem_addr",  {24'd0, mem_addr},  32'd0);
    chk("rst_mem_wdata", {16'd0, mem_w_data}, 32'd0);
    chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("rst_dm_rvalid", {31'd0, dm_rvalid}, 32'd0);
    chk("rst_if_rdata",  {16'd0, if_rdata},  32'd0);
    chk("rst_dm_rdata",  {16'd0, dm_rdata},  32'd0);
    chk("rst_wait_cnt",  {16'd0, if_wait_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cyc++;
  endtask

  logic          r_ir, r_dr, r_dw, r_fl;
  logic [AW-1:0] r_ia, r_da;
  logic [DW-1:0] r_wd;

  initial begin
    n_vec = 0; n_bad = 0; cyc = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[5] = 16'h1234; ref_mem[5] = 16'h1234;
    mem_r_data = '0;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0; flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    model_reset();
    #1;
    model_comb();
    check_all();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Lone IF read of address 5, data 0x1234 two cycles later.
    cycle(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(3);
    chk("if_read_addr5_held", {16'd0, if_rdata}, 32'h1234);

    // DM write then read of the same address.
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 8'd0, 16'h0007);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 8'd0, '0);
    idle(3);
    chk("dm_raw_held", {16'd0, dm_rdata}, 32'h0007);

    // Both requesters held: DM wins LIMIT cycles, then IF once.
    for (int i = 0; i < 4 * (LIMIT + 1); i++)
      cycle(1'b1, 8'(i), 1'b0, 1'b1, 1'b0, 8'(i + 32), '0);
    idle(3);

    // IF read, then a DM read under flush: IF return dropped, DM return kept.
    cycle(1'b1, 8'd9, 1'b0, 1'b0, 1'b0, '0, '0);
    cycle(1'b1, 8'd10, 1'b1, 1'b1, 1'b0, 8'd11, '0);
    idle(3);

    // Reads in flight when reset hits: none may return afterwards.
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 8'd3, '0);
    cycle(1'b1, 8'd4, 1'b0, 1'b0, 1'b0, '0, '0);
    do_reset();
    idle(4);

    // Randomized traffic with requests held until granted.
    r_ir = 1'b0; r_dr = 1'b0; r_dw = 1'b0; r_ia = '0; r_da = '0; r_wd = '0;
    for (int i = 0; i < 2000; i++) begin
      if (!r_ir) begin r_ir = 1'($urandom_range(0, 1)); r_ia = 8'($urandom_range(0, 15)); end
      if (!r_dr) begin
        r_dr = 1'($urandom_range(0, 1)); r_dw = 1'($urandom_range(0, 1));
        r_da = 8'($urandom_range(0, 15)); r_wd = 16'($urandom);
      end
      r_fl = ($urandom_range(0, 9) == 0);
      cycle(r_ir, r_ia, r_fl, r_dr, r_dw, r_da, r_wd);
      if (e_if_gnt) r_ir = 1'b0;
      if (e_dm_gnt) r_dr = 1'b0;
    end
    idle(3);

    // IF held under continuous flush never wins; wait count must saturate.
    do_reset();
    for (int i = 0; i < 65540; i++) cycle(1'b1, 8'd1, 1'b1, 1'b0, 1'b0, '0, '0);
    chk("wait_cnt_saturated", {16'd0, if_wait_cnt}, 32'h0000FFFF);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
